round_key_store: RTL and testbench

- Caches all round keys produced by the per-round key expansion stage, indexed by round number (0 = cipher key, 10 = final round key).
- Lets the inverse cipher consume round keys in reverse order without re-running the expansion.
- Sits directly downstream of the key expansion block's 128-bit round-key output.
- Provides a 1-cycle random-read port and a valid/ready stream port (forward or reverse).

---
 rtl/round_key_store.sv | 135 +++++++++++++
 tb/tb_round_key_store.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_key_store.sv
// Round key store: caches the AES-128 round keys coming out of the key
// expansion stage so the inverse cipher can replay them in either order.
// Offers a 1-cycle random-read port and a valid/ready stream port.
module round_key_store #(
    parameter int KEY_WIDTH = 128,
    parameter int NUM_KEYS  = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 wr_en,
    input  logic [3:0]           wr_idx,
    input  logic [KEY_WIDTH-1:0] wr_key,
    output logic                 wr_err,
    output logic [NUM_KEYS-1:0]  valid_mask,
    output logic                 all_valid,
    input  logic                 rd_en,
    input  logic [3:0]           rd_idx,
    output logic [KEY_WIDTH-1:0] rd_key,
    output logic                 rd_hit,
    input  logic                 stream_start,
    input  logic                 stream_rev,
    output logic                 start_err,
    output logic                 s_valid,
    input  logic                 s_ready,
    output logic [KEY_WIDTH-1:0] s_key,
    output logic [3:0]           s_idx,
    output logic                 s_last,
    output logic                 busy,
    output logic                 done
);

    localparam logic [4:0] KEY_COUNT = 5'(NUM_KEYS);
    localparam logic [3:0] LAST_IDX  = 4'(NUM_KEYS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t               state, state_next;
    logic [KEY_WIDTH-1:0] mem [NUM_KEYS];
    logic [3:0]           idx, idx_next;
    logic                 rev, rev_next;
    logic                 wr_in_range, rd_in_range;
    logic                 wr_ok, wr_bad, beat;

    assign wr_in_range = ({1'b0, wr_idx} < KEY_COUNT);
    assign rd_in_range = ({1'b0, rd_idx} < KEY_COUNT);

    // Writes are only accepted while idle so a running stream never sees a key change under it.
    assign wr_ok  = wr_en && !clear && (state == IDLE) && wr_in_range;
    assign wr_bad = wr_en && !clear && (!wr_in_range || (state == STREAM));

    assign all_valid = &valid_mask;
    assign busy      = (state == STREAM);
    assign s_valid   = (state == STREAM);
    assign s_key     = s_valid ? mem[idx] : '0;
    assign s_idx     = s_valid ? idx : 4'd0;
    assign s_last    = s_valid && (idx == (rev ? 4'd0 : LAST_IDX));
    assign beat      = s_valid && s_ready;

    // Key storage is deliberately left unreset; the valid mask says what is meaningful.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_idx] <= wr_key;
        end
    end

    // Random-read port: registered, holds when idle, sees pre-write contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_key <= '0;
            rd_hit <= 1'b0;
        end else if (rd_en) begin
            rd_key <= rd_in_range ? mem[rd_idx] : '0;
            rd_hit <= rd_in_range ? valid_mask[rd_idx] : 1'b0;
        end
    end

    // Stream FSM next-state: direction latched at start, index walks toward the last beat.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        rev_next   = rev;
        if (clear) begin
            state_next = IDLE;
            idx_next   = 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (stream_start && all_valid) begin
                        state_next = STREAM;
                        rev_next   = stream_rev;
                        idx_next   = stream_rev ? LAST_IDX : 4'd0;
                    end
                end
                STREAM: begin
                    if (beat) begin
                        if (s_last) begin
                            state_next = IDLE;
                            idx_next   = 4'd0;
                        end else begin
                            idx_next = rev ? (idx - 4'd1) : (idx + 4'd1);
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State, valid mask and the single-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 4'd0;
            rev        <= 1'b0;
            valid_mask <= '0;
            wr_err     <= 1'b0;
            start_err  <= 1'b0;
            done       <= 1'b0;
        end else begin
            state     <= state_next;
            idx       <= idx_next;
            rev       <= rev_next;
            wr_err    <= wr_bad;
            start_err <= stream_start && !clear && (state == IDLE) && !all_valid;
            done      <= beat && s_last && !clear;
            if (clear) begin
                valid_mask <= '0;
            end else if (wr_ok) begin
                valid_mask[wr_idx] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_round_key_store.sv
// Self-checking bench for round_key_store: a small reference model of the
// key array plus scoreboard queues for read results and stream beats.
module tb_round_key_store;

    localparam int KW = 128;
    localparam int NK = 11;

    typedef struct {
        logic [KW-1:0] key;
        logic [3:0]    idx;
        logic          last;
    } beat_t;

    typedef struct {
        logic [KW-1:0] key;
        logic          hit;
        bit            known;
    } rd_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          wr_en = 1'b0;
    logic [3:0]    wr_idx = 4'd0;
    logic [KW-1:0] wr_key = '0;
    logic          wr_err;
    logic [NK-1:0] valid_mask;
    logic          all_valid;
    logic          rd_en = 1'b0;
    logic [3:0]    rd_idx = 4'd0;
    logic [KW-1:0] rd_key;
    logic          rd_hit;
    logic          stream_start = 1'b0;
    logic          stream_rev = 1'b0;
    logic          start_err;
    logic          s_valid;
    logic          s_ready = 1'b0;
    logic [KW-1:0] s_key;
    logic [3:0]    s_idx;
    logic          s_last;
    logic          busy;
    logic          done;

    int pass_cnt = 0;
    int check_cnt = 0;

    logic [KW-1:0] fips [NK] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    logic [KW-1:0] exp_mem [NK];
    logic [NK-1:0] exp_valid = '0;
    beat_t         exp_q[$];
    rd_t           rd_q[$];

    round_key_store #(.KEY_WIDTH(KW), .NUM_KEYS(NK)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key), .wr_err(wr_err),
        .valid_mask(valid_mask), .all_valid(all_valid),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_key(rd_key), .rd_hit(rd_hit),
        .stream_start(stream_start), .stream_rev(stream_rev), .start_err(start_err),
        .s_valid(s_valid), .s_ready(s_ready), .s_key(s_key), .s_idx(s_idx),
        .s_last(s_last), .busy(busy), .done(done)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Single idle-state write; updates the model only when the index is storable.
    task automatic write_key(input logic [3:0] i, input logic [KW-1:0] k);
        wr_en  = 1'b1;
        wr_idx = i;
        wr_key = k;
        @(negedge clk);
        wr_en = 1'b0;
        if (i < NK) begin
            exp_mem[i]   = k;
            exp_valid[i] = 1'b1;
        end
    endtask

    // Random read, optionally with a same-cycle write to exercise read-before-write.
    task automatic do_read(input logic [3:0] i, input bit with_wr, input logic [KW-1:0] wk);
        rd_t e;
        e.hit   = (i < NK) ? exp_valid[i] : 1'b0;
        e.key   = (i < NK) ? exp_mem[i] : '0;
        e.known = (i >= NK) || e.hit;
        rd_q.push_back(e);
        rd_en  = 1'b1;
        rd_idx = i;
        if (with_wr) begin
            wr_en  = 1'b1;
            wr_idx = i;
            wr_key = wk;
        end
        @(negedge clk);
        rd_en = 1'b0;
        wr_en = 1'b0;
        if (with_wr && i < NK) begin
            exp_mem[i]   = wk;
            exp_valid[i] = 1'b1;
        end
        e = rd_q.pop_front();
        check_cnt++;
        if (rd_hit !== e.hit) $display("[TB] FAIL rd_hit idx=%0d got=%b exp=%b", i, rd_hit, e.hit);
        else pass_cnt++;
        if (e.known) begin
            check_cnt++;
            if (rd_key !== e.key) $display("[TB] FAIL rd_key idx=%0d got=%h exp=%h", i, rd_key, e.key);
            else pass_cnt++;
        end
    endtask

    // Full stream with scoreboarded beats; optional ready toggling and a write attempt mid-stream.
    task automatic run_stream(input logic rev, input bit toggle, input bit wr_during);
        beat_t b;
        beat_t held;
        bit    have_held;
        logic  rdy;
        int    cyc;
        for (int k = 0; k < NK; k++) begin
            int i;
            i = rev ? (NK - 1 - k) : k;
            b.key  = exp_mem[i];
            b.idx  = 4'(i);
            b.last = (k == NK - 1);
            exp_q.push_back(b);
        end
        stream_start = 1'b1;
        stream_rev   = rev;
        s_ready      = 1'b0;
        @(negedge clk);
        stream_start = 1'b0;
        stream_rev   = ~rev;
        check_cnt++;
        if (busy !== 1'b1 || start_err !== 1'b0) $display("[TB] FAIL stream_entry busy=%b start_err=%b exp busy=1 start_err=0", busy, start_err);
        else pass_cnt++;
        cyc = 0;
        have_held = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            if (have_held) begin
                check_cnt++;
                if (s_key !== held.key || s_idx !== held.idx || s_last !== held.last)
                    $display("[TB] FAIL stream_hold got idx=%0d key=%h exp idx=%0d key=%h", s_idx, s_key, held.idx, held.key);
                else pass_cnt++;
            end
            if (wr_during && cyc == 4) begin
                wr_en = 1'b0;
                check_cnt++;
                if (wr_err !== 1'b1) $display("[TB] FAIL wr_err_stream got=%b exp=1", wr_err);
                else pass_cnt++;
            end
            if (wr_during && cyc == 5) begin
                check_cnt++;
                if (wr_err !== 1'b0) $display("[TB] FAIL wr_err_pulse got=%b exp=0", wr_err);
                else pass_cnt++;
            end
            check_cnt++;
            if (s_valid !== 1'b1) $display("[TB] FAIL stream_valid cyc=%0d got=%b exp=1", cyc, s_valid);
            else pass_cnt++;
            rdy = toggle ? ((cyc % 2) == 0) : 1'b1;
            s_ready = rdy;
            if (wr_during && cyc == 3) begin
                wr_en  = 1'b1;
                wr_idx = 4'd2;
                wr_key = '1;
            end
            if (s_valid === 1'b1 && rdy) begin
                b = exp_q.pop_front();
                check_cnt++;
                if (s_key !== b.key || s_idx !== b.idx || s_last !== b.last)
                    $display("[TB] FAIL stream_beat got idx=%0d key=%h last=%b exp idx=%0d key=%h last=%b", s_idx, s_key, s_last, b.idx, b.key, b.last);
                else pass_cnt++;
                have_held = 0;
            end else begin
                held.key  = s_key;
                held.idx  = s_idx;
                held.last = s_last;
                have_held = (s_valid === 1'b1);
            end
            @(negedge clk);
            cyc++;
        end
        s_ready = 1'b0;
        check_cnt++;
        if (exp_q.size() != 0) $display("[TB] FAIL stream_timeout left=%0d exp=0", exp_q.size());
        else pass_cnt++;
        exp_q.delete();
        check_cnt++;
        if (cyc != (toggle ? 2 * NK - 1 : NK)) $display("[TB] FAIL stream_cycles got=%0d exp=%0d", cyc, toggle ? 2 * NK - 1 : NK);
        else pass_cnt++;
        check_cnt++;
        if (done !== 1'b1 || busy !== 1'b0 || s_valid !== 1'b0) $display("[TB] FAIL stream_done done=%b busy=%b s_valid=%b exp 1 0 0", done, busy, s_valid);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (done !== 1'b0) $display("[TB] FAIL done_pulse got=%b exp=0", done);
        else pass_cnt++;
    endtask

    // Reset values during and just after reset.
    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_cnt++;
        if ({valid_mask, all_valid, rd_key, rd_hit, s_valid, s_key, s_idx, s_last, busy, done, wr_err, start_err} !== '0)
            $display("[TB] FAIL reset_outputs got nonzero valid_mask=%h rd_key=%h s_valid=%b busy=%b exp all 0", valid_mask, rd_key, s_valid, busy);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        check_cnt++;
        if (valid_mask !== '0 || busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL post_reset valid_mask=%h busy=%b exp 0 0", valid_mask, busy);
        else pass_cnt++;
    endtask

    // Basic writes, reads, hold, out-of-range read and read-before-write.
    task automatic test_write_read();
        write_key(4'd0, fips[0]);
        write_key(4'd1, fips[1]);
        check_cnt++;
        if (valid_mask !== 11'h003 || all_valid !== 1'b0) $display("[TB] FAIL mask_two got=%h all=%b exp=003 all=0", valid_mask, all_valid);
        else pass_cnt++;
        do_read(4'd1, 0, '0);
        rd_idx = 4'd0;
        @(negedge clk);
        check_cnt++;
        if (rd_key !== fips[1] || rd_hit !== 1'b1) $display("[TB] FAIL rd_hold got=%h hit=%b exp=%h hit=1", rd_key, rd_hit, fips[1]);
        else pass_cnt++;
        do_read(4'd2, 0, '0);
        do_read(4'd0, 1, fips[5]);
        do_read(4'd0, 0, '0);
        write_key(4'd0, fips[0]);
        do_read(4'd0, 0, '0);
        do_read(4'd12, 0, '0);
    endtask

    // Out-of-range write is rejected with a pulse and no state change.
    task automatic test_bad_write();
        write_key(4'd11, '1);
        check_cnt++;
        if (wr_err !== 1'b1 || valid_mask !== exp_valid) $display("[TB] FAIL wr_err_range err=%b mask=%h exp err=1 mask=%h", wr_err, valid_mask, exp_valid);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (wr_err !== 1'b0) $display("[TB] FAIL wr_err_clear got=%b exp=0", wr_err);
        else pass_cnt++;
    endtask

    // Start with a hole in the table is refused; the hole reads as a miss.
    task automatic test_start_err();
        for (int i = 2; i < NK; i++) if (i != 5) write_key(4'(i), fips[i]);
        stream_start = 1'b1;
        stream_rev   = 1'b1;
        @(negedge clk);
        stream_start = 1'b0;
        check_cnt++;
        if (start_err !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL start_err got=%b busy=%b exp 1 0", start_err, busy);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (start_err !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL start_err_pulse got=%b busy=%b exp 0 0", start_err, busy);
        else pass_cnt++;
        do_read(4'd5, 0, '0);
        write_key(4'd5, fips[5]);
        check_cnt++;
        if (all_valid !== 1'b1 || valid_mask !== 11'h7ff) $display("[TB] FAIL all_valid got=%b mask=%h exp 1 7ff", all_valid, valid_mask);
        else pass_cnt++;
    endtask

    task automatic test_stream_rev();
        run_stream(1'b1, 0, 0);
    endtask

    task automatic test_stream_fwd_toggle();
        run_stream(1'b0, 1, 0);
    endtask

    // Write attempted mid-stream must bounce and leave both stream and storage intact.
    task automatic test_write_during_stream();
        run_stream(1'b0, 0, 1);
        check_cnt++;
        if (valid_mask !== exp_valid) $display("[TB] FAIL mask_after_wr got=%h exp=%h", valid_mask, exp_valid);
        else pass_cnt++;
        do_read(4'd2, 0, '0);
    endtask

    // Synchronous clear at beat 4 abandons the stream with no done pulse.
    task automatic test_clear_abort();
        bit seen_done;
        stream_start = 1'b1;
        stream_rev   = 1'b0;
        s_ready      = 1'b1;
        @(negedge clk);
        stream_start = 1'b0;
        repeat (4) @(negedge clk);
        check_cnt++;
        if (s_idx !== 4'd4 || s_key !== fips[4]) $display("[TB] FAIL clear_beat4 idx=%0d exp=4", s_idx);
        else pass_cnt++;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_valid = '0;
        check_cnt++;
        if (s_valid !== 1'b0 || busy !== 1'b0 || valid_mask !== '0 || all_valid !== 1'b0)
            $display("[TB] FAIL clear_abort s_valid=%b busy=%b mask=%h exp 0 0 000", s_valid, busy, valid_mask);
        else pass_cnt++;
        seen_done = 0;
        for (int c = 0; c < 12; c++) begin
            if (done === 1'b1) seen_done = 1;
            @(negedge clk);
        end
        s_ready = 1'b0;
        check_cnt++;
        if (seen_done) $display("[TB] FAIL clear_no_done got=1 exp=0");
        else pass_cnt++;
    endtask

    // Asynchronous reset mid-stream takes effect without waiting for a clock.
    task automatic test_reset_abort();
        bit seen_done;
        for (int i = 0; i < NK; i++) write_key(4'(i), fips[i]);
        stream_start = 1'b1;
        stream_rev   = 1'b1;
        s_ready      = 1'b1;
        @(negedge clk);
        stream_start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_valid = '0;
        check_cnt++;
        if (s_valid !== 1'b0 || busy !== 1'b0 || valid_mask !== '0) $display("[TB] FAIL reset_abort s_valid=%b busy=%b mask=%h exp 0 0 000", s_valid, busy, valid_mask);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 12; c++) begin
            if (done === 1'b1 || busy === 1'b1) seen_done = 1;
            @(negedge clk);
        end
        s_ready = 1'b0;
        check_cnt++;
        if (seen_done) $display("[TB] FAIL reset_no_done got=1 exp=0");
        else pass_cnt++;
    endtask

    // Test sequence
    initial begin
        test_reset();
        test_write_read();
        test_bad_write();
        test_start_err();
        test_stream_rev();
        test_stream_fwd_toggle();
        test_write_during_stream();
        test_clear_abort();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
